// File: rtl/ser_pkg.sv
// Shared definitions for the serial link: byte width, bit counter width and
// the transmitter state encoding. The receiver reuses BYTE_W.
package ser_pkg;

    localparam int BYTE_W   = 8;
    localparam int BITCNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with first-word-visible read data. Writes while full
// and reads while empty are ignored, so callers may drive the enables freely.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + CW'(1);
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/parallel_to_serial_tx.sv
// Byte-to-serial transmitter feeding the serial-to-parallel receiver.
// Bytes are queued in a FIFO and shifted out LSB-first. Each burst starts with
// one lead cycle (the receiver ignores its first enabled cycle); bytes that are
// already queued when the previous byte ends follow with no gap.
// Serial outputs are registered from the current state, so they trail the FSM
// by one cycle; TxCount steps when the final bit of a byte has left the pin.
module parallel_to_serial_tx
    import ser_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              InValid,
    input  logic [BYTE_W-1:0] InData,
    output logic              InReady,
    output logic              SerEnable,
    output logic              SerData,
    output logic              Busy,
    output logic [7:0]        TxCount
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t           state;
    tx_state_t           next_state;
    logic                pop;
    logic [BYTE_W-1:0]   fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [BYTE_W-1:0]   shreg;
    logic [BITCNT_W-1:0] bitcnt;
    logic                last_bit_p1;

    byte_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .wr_en   (InValid),
        .wr_data (InData),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign InReady = !fifo_full;
    assign Busy    = (state != IDLE) || (fifo_count != '0);

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and FIFO pop decode; a queued byte chains directly after bit 7.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = LEAD;
                end
            end
            LEAD: begin
                pop        = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                if (bitcnt == BITCNT_W'(7)) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift register: loaded from the FIFO head on every pop.
    always_ff @(posedge CLK) begin
        if (pop) begin
            shreg <= fifo_head;
        end
    end

    // Bit counter: restarts on each new byte, advances while shifting.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bitcnt <= '0;
        end else if (pop) begin
            bitcnt <= '0;
        end else if (state == SHIFT) begin
            bitcnt <= bitcnt + BITCNT_W'(1);
        end
    end

    // Registered serial outputs and completed-byte counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            SerEnable   <= 1'b0;
            SerData     <= 1'b0;
            last_bit_p1 <= 1'b0;
            TxCount     <= 8'd0;
        end else begin
            SerEnable   <= (state != IDLE);
            SerData     <= (state == SHIFT) ? shreg[bitcnt] : 1'b0;
            last_bit_p1 <= (state == SHIFT) && (bitcnt == BITCNT_W'(7));
            if (last_bit_p1) begin
                TxCount <= TxCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
`timescale 1ns/1ps
module tb_parallel_to_serial_tx;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       InValid = 1'b0;
    logic [7:0] InData = 8'h00;
    logic       InReady;
    logic       SerEnable;
    logic       SerData;
    logic       Busy;
    logic [7:0] TxCount;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] stim_q [$];

    // receiver model state
    logic       prev_en = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_bitidx = 0;
    int         burst_bits = 0;
    int         last_burst_bits = 0;
    int         bursts = 0;
    bit         seen_full_empty = 0;

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vecs [4];

    parallel_to_serial_tx #(.FIFO_DEPTH(4)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .InValid   (InValid),
        .InData    (InData),
        .InReady   (InReady),
        .SerEnable (SerEnable),
        .SerData   (SerData),
        .Busy      (Busy),
        .TxCount   (TxCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receiver model: skip the first enabled cycle, then collect LSB-first bytes.
    always @(negedge CLK) begin
        if (!RSTn) begin
            prev_en    = 1'b0;
            rx_bitidx  = 0;
            burst_bits = 0;
        end else begin
            if (dut.u_fifo.full && dut.u_fifo.empty) seen_full_empty = 1;
            if (SerEnable && !prev_en) begin
                burst_bits = 0;
                rx_bitidx  = 0;
            end else if (SerEnable && prev_en) begin
                rx_sh = {SerData, rx_sh[7:1]};
                rx_bitidx++;
                burst_bits++;
                if (rx_bitidx == 8) begin
                    rx_bitidx = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected_byte: got %0h expected none", rx_sh);
                    end else begin
                        check("rx_byte", {24'd0, rx_sh}, {24'd0, exp_q.pop_front()});
                    end
                end
            end else if (!SerEnable && prev_en) begin
                bursts++;
                last_burst_bits = burst_bits;
            end
            prev_en = SerEnable;
        end
    end

    task automatic do_reset();
        RSTn    = 1'b0;
        InValid = 1'b0;
        repeat (3) @(negedge CLK);
        exp_q.delete();
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    // Stream stim_q with InValid held high; one new byte per accepted beat.
    task automatic send_stream(output bit saw_full);
        int n = stim_q.size();
        int sent = 0;
        int guard = 0;
        saw_full = 0;
        @(negedge CLK);
        while (sent < n && guard < n * 20 + 100) begin
            InValid = 1'b1;
            InData  = stim_q[sent];
            if (InReady) begin
                exp_q.push_back(stim_q[sent]);
                sent++;
            end else begin
                saw_full = 1;
            end
            guard++;
            @(negedge CLK);
        end
        InValid = 1'b0;
        if (sent < n) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d expected %0d bytes", sent, n);
        end
        stim_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((Busy || SerEnable) && n < budget);
        @(negedge CLK);
        check("idle_reached", {30'd0, Busy, SerEnable}, 32'd0);
        check("all_bytes_out", exp_q.size(), 0);
    endtask

    initial begin
        bit   full_seen;
        int   b0;
        logic [7:0] a5;

        vecs[0] = '{data: 8'h3C, gap: 0, exp_tx: 8'd11};
        vecs[1] = '{data: 8'h00, gap: 5, exp_tx: 8'd12};
        vecs[2] = '{data: 8'hFF, gap: 5, exp_tx: 8'd13};
        vecs[3] = '{data: 8'h81, gap: 2, exp_tx: 8'd14};

        // Reset values
        do_reset();
        check("rst_SerEnable", SerEnable, 1'b0);
        check("rst_SerData", SerData, 1'b0);
        check("rst_TxCount", TxCount, 8'd0);
        check("rst_InReady", InReady, 1'b1);
        check("rst_Busy", Busy, 1'b0);

        // Single byte A5 with cycle-exact framing
        a5 = 8'hA5;
        InValid = 1'b1;
        InData  = a5;
        exp_q.push_back(a5);
        @(posedge CLK);
        for (int k = 0; k <= 12; k++) begin
            @(negedge CLK);
            InValid = 1'b0;
            check($sformatf("lat_en_k%0d", k), SerEnable, (k >= 2 && k <= 10));
            if (k >= 3 && k <= 10)
                check($sformatf("lat_bit_k%0d", k), SerData, a5[k-3]);
            if (k == 10) check("lat_tx_before", TxCount, 8'd0);
            if (k == 11) check("lat_tx_after", TxCount, 8'd1);
        end
        wait_idle(50);
        check("a5_burst_bits", last_burst_bits, 8);

        // Three bytes back-to-back: one lead, 24 contiguous bits
        b0 = bursts;
        stim_q = '{8'h01, 8'h80, 8'hFF};
        send_stream(full_seen);
        wait_idle(200);
        check("b2b_burst_bits", last_burst_bits, 24);
        check("b2b_bursts", bursts, b0 + 1);
        check("b2b_TxCount", TxCount, 8'd4);

        // Six bytes with InValid held: FIFO fills, nothing lost
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_stream(full_seen);
        check("six_saw_full", full_seen, 1'b1);
        wait_idle(300);
        check("six_TxCount", TxCount, 8'd10);
        check("six_burst_bits", last_burst_bits, 48);

        // Table: isolated bytes with idle gaps, each its own burst
        for (int i = 0; i < 4; i++) begin
            repeat (vecs[i].gap) @(negedge CLK);
            b0 = bursts;
            stim_q = '{vecs[i].data};
            send_stream(full_seen);
            wait_idle(100);
            check($sformatf("vec%0d_TxCount", i), TxCount, vecs[i].exp_tx);
            check($sformatf("vec%0d_burst_bits", i), last_burst_bits, 8);
            check($sformatf("vec%0d_bursts", i), bursts, b0 + 1);
        end

        // Reset mid-byte with bytes still queued
        stim_q = '{8'hC3, 8'h5A, 8'h96};
        send_stream(full_seen);
        begin
            int n = 0;
            while (!(SerEnable && rx_bitidx == 4) && n < 100) begin
                @(negedge CLK);
                n++;
            end
            check("midrst_reached_bit4", (n < 100), 1'b1);
        end
        #1 RSTn = 1'b0;
        #1;
        check("midrst_SerEnable", SerEnable, 1'b0);
        check("midrst_InReady", InReady, 1'b1);
        check("midrst_TxCount", TxCount, 8'd0);
        check("midrst_Busy", Busy, 1'b0);
        repeat (2) @(negedge CLK);
        exp_q.delete();
        RSTn = 1'b1;
        begin
            bit quiet = 1;
            repeat (20) begin
                @(negedge CLK);
                if (SerEnable || Busy) quiet = 0;
            end
            check("postrst_quiet", quiet, 1'b1);
        end

        // 257 bytes: TxCount wraps to 1
        for (int i = 0; i < 257; i++) stim_q.push_back(8'((i * 37 + 5) & 255));
        send_stream(full_seen);
        wait_idle(5000);
        check("wrap_TxCount", TxCount, 8'd1);
        check("wrap_burst_bits", last_burst_bits, 257 * 8);
        check("fifo_full_and_empty", seen_full_empty, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
